// File: rtl/interrupt_service.sv
// Host-side servicer for the 2-bit frame-statistics interrupt: qualifies the pin, latches the state,
// runs grey/wb req-ack handshakes and returns a clear pulse. Optional ack timeout: INT_SERVICE_TIMEOUT_EN.
module interrupt_service #(
  parameter int PULSE_MIN_CYC   = 8,
  parameter int ACK_TIMEOUT_CYC = 4096,
  parameter int CNT_WD          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_interrupt,
  input  logic [1:0]        iv_interrupt_state,
  output logic              o_grey_req,
  input  logic              i_grey_ack,
  output logic              o_wb_req,
  input  logic              i_wb_ack,
  output logic [1:0]        ov_interrupt_clear,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_timeout,
  output logic [CNT_WD-1:0] ov_service_cnt,
  output logic [2:0]        o_dbg_state
);

  localparam int QW = $clog2(PULSE_MIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_GREY  = 3'd2,
    S_WB    = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              int_s_q, int_s_d;
  logic [QW-1:0]     qual_cnt_q, qual_cnt_d;
  logic              qual_event_q, qual_event_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [1:0]        pend_q, pend_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              wait_expired;

  // Handshake: a req is a level held while its state is active; the matching ack is only
  // looked at while that req is high, and an ack seen on the first req cycle completes it.
  always_comb begin
    sync1_d      = i_interrupt;
    int_s_d      = sync1_q;
    qual_cnt_d   = qual_cnt_q;
    qual_event_d = 1'b0;
    state_d      = state_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;

    if (!int_s_q) begin
      qual_cnt_d = '0;
    end else if (qual_cnt_q != QW'(PULSE_MIN_CYC)) begin
      qual_cnt_d = qual_cnt_q + 1'b1;
    end
    // Fires once per pulse: only on the step from PULSE_MIN_CYC-1 to the saturation value.
    qual_event_d = int_s_q && (qual_cnt_q == QW'(PULSE_MIN_CYC - 1));

    if (qual_event_q && (state_q != S_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (qual_event_q || pending_q) begin
          state_d   = S_LATCH;
          pending_d = qual_event_q && pending_q;
        end
      end
      S_LATCH: begin
        pend_d = iv_interrupt_state;
        if (iv_interrupt_state[0])      state_d = S_GREY;
        else if (iv_interrupt_state[1]) state_d = S_WB;
        else                            state_d = S_IDLE;
      end
      S_GREY: begin
        if (i_grey_ack || wait_expired) state_d = pend_q[1] ? S_WB : S_CLEAR;
      end
      S_WB: begin
        if (i_wb_ack || wait_expired) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    o_grey_req         = (state_q == S_GREY);
    o_wb_req           = (state_q == S_WB);
    ov_interrupt_clear = (state_q == S_CLEAR) ? pend_q : 2'b00;
    o_busy             = (state_q != S_IDLE);
    o_overrun          = overrun_q;
    ov_service_cnt     = cnt_q;
    o_dbg_state        = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      int_s_q      <= 1'b0;
      qual_cnt_q   <= '0;
      qual_event_q <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pend_q       <= 2'b00;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      int_s_q      <= int_s_d;
      qual_cnt_q   <= qual_cnt_d;
      qual_event_q <= qual_event_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef INT_SERVICE_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          in_wait;

  // The wait counter restarts on every state change, so GREY->WB gets a fresh budget.
  always_comb begin
    in_wait      = (state_q == S_GREY) || (state_q == S_WB);
    wait_expired = in_wait && (wait_cnt_q == TW'(ACK_TIMEOUT_CYC - 1));
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    if ((state_d != state_q) || !in_wait) wait_cnt_d = '0;
    else                                  wait_cnt_d = wait_cnt_q + 1'b1;
    if (wait_expired && !(o_grey_req && i_grey_ack) && !(o_wb_req && i_wb_ack)) timeout_d = 1'b1;
    o_timeout = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  always_comb begin
    wait_expired = 1'b0;
    o_timeout    = 1'b0;
  end
`endif

endmodule

// File: tb/tb_interrupt_service.sv
// Bench for interrupt_service: vector table of single pulses plus hand sequences for pending,
// overrun, held acks, reset mid-service and ack timeout; clear pulses are scoreboarded.
module tb_interrupt_service;
  localparam int P  = 8;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_interrupt;
  logic [1:0]    iv_interrupt_state;
  logic          o_grey_req, i_grey_ack, o_wb_req, i_wb_ack;
  logic [1:0]    ov_interrupt_clear;
  logic          o_busy, o_overrun, o_timeout;
  logic [CW-1:0] ov_service_cnt;
  logic [2:0]    o_dbg_state;

  interrupt_service #(.PULSE_MIN_CYC(P), .ACK_TIMEOUT_CYC(TO), .CNT_WD(CW)) dut (
    .clk(clk), .reset(reset), .i_interrupt(i_interrupt), .iv_interrupt_state(iv_interrupt_state),
    .o_grey_req(o_grey_req), .i_grey_ack(i_grey_ack), .o_wb_req(o_wb_req), .i_wb_ack(i_wb_ack),
    .ov_interrupt_clear(ov_interrupt_clear), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_timeout(o_timeout), .ov_service_cnt(ov_service_cnt), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- handler responders ----------------
  bit grey_ack_en = 1'b1, wb_ack_en = 1'b1;
  int grey_dly = 0, wb_dly = 0;

  initial begin
    i_grey_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (grey_ack_en && o_grey_req) begin
        repeat (grey_dly) @(negedge clk);
        i_grey_ack = 1'b1;
        for (int k = 0; k < 50 && o_grey_req; k++) @(negedge clk);
        i_grey_ack = 1'b0;
      end
    end
  end

  initial begin
    i_wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_ack_en && o_wb_req) begin
        repeat (wb_dly) @(negedge clk);
        i_wb_ack = 1'b1;
        for (int k = 0; k < 50 && o_wb_req; k++) @(negedge clk);
        i_wb_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int grey_hi = 0, wb_hi = 0, first_req_cyc = -1;
  bit busy_seen = 1'b0;
  logic [1:0] prev_clr = 2'b00;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_grey_req || o_wb_req) chk("req_overlap", {31'd0, o_grey_req && o_wb_req}, 0);
      if (o_grey_req) grey_hi++;
      if (o_wb_req) wb_hi++;
      if (o_busy) busy_seen = 1'b1;
      if ((o_grey_req || o_wb_req) && first_req_cyc < 0) first_req_cyc = cyc;
      if (ov_interrupt_clear != 2'b00) begin
        chk("clear_width", {30'd0, prev_clr}, 0);
        if (exp_q.size() == 0) chk("clear_unexpected", {30'd0, ov_interrupt_clear}, 0);
        else chk("clear_val", {30'd0, ov_interrupt_clear}, {30'd0, exp_q.pop_front()});
      end
      prev_clr = ov_interrupt_clear;
    end else begin
      prev_clr = 2'b00;
    end
  end

  // ---------------- driver tasks ----------------
  int pulse_cyc = 0;

  task automatic pulse(input int len, input logic [1:0] st);
    @(negedge clk);
    iv_interrupt_state = st;
    i_interrupt = 1'b1;
    pulse_cyc = cyc;
    repeat (len) @(negedge clk);
    i_interrupt = 1'b0;
  endtask

  task automatic clear_stats();
    grey_hi = 0; wb_hi = 0; busy_seen = 1'b0; first_req_cyc = -1;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2000; k++) begin
      if (!o_busy && exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("settle_busy", {31'd0, o_busy}, 0);
    chk("clear_missing", exp_q.size(), 0);
  endtask

  task automatic wait_req(input bit wb);
    for (int k = 0; k < 400; k++) begin
      if (wb ? o_wb_req : o_grey_req) break;
      @(negedge clk);
    end
    chk(wb ? "wait_wb_req" : "wait_grey_req", {31'd0, wb ? o_wb_req : o_grey_req}, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         len;
    logic [1:0] st;
    int         gdly;
    int         wdly;
    bit         exp_grey;
    bit         exp_wb;
    bit         exp_busy;
    logic [1:0] exp_clr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{20, 2'b01, 5, 0, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[1] = '{20, 2'b11, 3, 2, 1'b1, 1'b1, 1'b1, 2'b11};
    vecs[2] = '{5,  2'b01, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[3] = '{7,  2'b01, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[4] = '{8,  2'b01, 1, 0, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[5] = '{20, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[6] = '{20, 2'b10, 0, 0, 1'b0, 1'b1, 1'b1, 2'b10};
    vecs[7] = '{20, 2'b01, 0, 0, 1'b1, 1'b0, 1'b1, 2'b01};

    reset = 1'b1;
    i_interrupt = 1'b0;
    iv_interrupt_state = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_grey_req", {31'd0, o_grey_req}, 0);
    chk("rst_wb_req", {31'd0, o_wb_req}, 0);
    chk("rst_clear", {30'd0, ov_interrupt_clear}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_overrun", {31'd0, o_overrun}, 0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    chk("rst_cnt", {16'd0, ov_service_cnt}, 0);
    chk("rst_state", {29'd0, o_dbg_state}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      grey_dly = vecs[i].gdly; wb_dly = vecs[i].wdly;
      grey_ack_en = 1'b1; wb_ack_en = 1'b1;
      clear_stats();
      if (vecs[i].exp_clr != 2'b00) begin
        exp_q.push_back(vecs[i].exp_clr);
        exp_cnt++;
      end
      pulse(vecs[i].len, vecs[i].st);
      settle();
      chk($sformatf("v%0d_grey_seen", i), {31'd0, grey_hi != 0}, {31'd0, vecs[i].exp_grey});
      chk($sformatf("v%0d_wb_seen", i), {31'd0, wb_hi != 0}, {31'd0, vecs[i].exp_wb});
      chk($sformatf("v%0d_busy_seen", i), {31'd0, busy_seen}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("v%0d_cnt", i), {16'd0, ov_service_cnt}, exp_cnt);
      if (vecs[i].exp_grey) chk($sformatf("v%0d_grey_len", i), grey_hi, vecs[i].gdly + 1);
      if (vecs[i].exp_wb) chk($sformatf("v%0d_wb_len", i), wb_hi, vecs[i].wdly + 1);
      if (vecs[i].exp_grey || vecs[i].exp_wb)
        chk($sformatf("v%0d_req_latency", i), first_req_cyc - pulse_cyc, 2 + P + 2);
    end

    // wb ack held high from before: ignored during GREY, completes WB on its first cycle
    grey_ack_en = 1'b1; grey_dly = 3; wb_ack_en = 1'b0;
    i_wb_ack = 1'b1;
    clear_stats();
    exp_q.push_back(2'b11); exp_cnt++;
    pulse(20, 2'b11);
    settle();
    chk("held_wb_grey_len", grey_hi, 4);
    chk("held_wb_wb_len", wb_hi, 1);
    i_wb_ack = 1'b0;

    // grey ack already high when req asserts
    grey_ack_en = 1'b0;
    i_grey_ack = 1'b1;
    clear_stats();
    exp_q.push_back(2'b01); exp_cnt++;
    pulse(20, 2'b01);
    settle();
    chk("held_grey_len", grey_hi, 1);
    chk("held_grey_cnt", {16'd0, ov_service_cnt}, exp_cnt);
    i_grey_ack = 1'b0;

    // pending pulse during GREY, third pulse overruns
    grey_ack_en = 1'b0; wb_ack_en = 1'b0;
    clear_stats();
    exp_q.push_back(2'b01); exp_cnt++;
    pulse(20, 2'b01);
    wait_req(1'b0);
    chk("ovr_before", {31'd0, o_overrun}, 0);
    exp_q.push_back(2'b11); exp_cnt++;
    pulse(20, 2'b11);
    chk("ovr_after_pending", {31'd0, o_overrun}, 0);
    pulse(20, 2'b11);
    repeat (2) @(negedge clk);
    chk("ovr_set", {31'd0, o_overrun}, 1);
    chk("ovr_still_grey", {31'd0, o_grey_req}, 1);
    grey_dly = 2; wb_dly = 2; grey_ack_en = 1'b1; wb_ack_en = 1'b1;
    settle();
    chk("ovr_cnt", {16'd0, ov_service_cnt}, exp_cnt);
    chk("ovr_sticky", {31'd0, o_overrun}, 1);

    // reset while wb req is high: everything drops, no clear
    wb_ack_en = 1'b0;
    pulse(20, 2'b10);
    wait_req(1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_wb_req", {31'd0, o_wb_req}, 0);
    chk("mid_rst_grey_req", {31'd0, o_grey_req}, 0);
    chk("mid_rst_clear", {30'd0, ov_interrupt_clear}, 0);
    chk("mid_rst_busy", {31'd0, o_busy}, 0);
    chk("mid_rst_overrun", {31'd0, o_overrun}, 0);
    chk("mid_rst_cnt", {16'd0, ov_service_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    wb_ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'd0, o_busy}, 0);

    // handler never acks
    grey_ack_en = 1'b0;
    clear_stats();
    exp_q.push_back(2'b01); exp_cnt++;
`ifdef INT_SERVICE_TIMEOUT_EN
    pulse(20, 2'b01);
    settle();
    chk("to_req_len", grey_hi, TO);
    chk("to_flag", {31'd0, o_timeout}, 1);
    chk("to_cnt", {16'd0, ov_service_cnt}, exp_cnt);
`else
    pulse(20, 2'b01);
    wait_req(1'b0);
    repeat (1000) @(negedge clk);
    chk("hold_req", {31'd0, o_grey_req}, 1);
    chk("hold_no_timeout", {31'd0, o_timeout}, 0);
    grey_dly = 0; grey_ack_en = 1'b1;
    settle();
    chk("hold_cnt", {16'd0, ov_service_cnt}, exp_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
